// File: rtl/ipc_cmd_scheduler.sv
// Round-robin arbiter that formats IPC commands into messages
// and sequences a single message writer through load/start/done.
module ipc_cmd_scheduler #(
   parameter int NREQ    = 4,
   parameter int WIDTH   = 64,
   parameter int TIMEOUT = 255
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NREQ-1:0]           req_valid,
   input  logic [NREQ*8-1:0]         req_cmd,
   input  logic [NREQ*(WIDTH-8)-1:0] req_arg,
   output logic [NREQ-1:0]           req_ack,
   output logic [WIDTH-1:0]          wr_data,
   output logic                      wr_load,
   input  logic                      wr_busy,
   output logic                      busy,
   output logic [$clog2(NREQ)-1:0]   last_grant,
   output logic                      err_timeout,
   input  logic                      err_clear,
   output logic [15:0]               msg_count
);

   localparam int GW = $clog2(NREQ);
   localparam int AW = WIDTH - 8;
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
   localparam logic [GW-1:0] PTR_RST = GW'(NREQ - 1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      WAIT_START,
      WAIT_DONE
   } state_t;

   state_t state, state_nxt;

   logic [15:0]      tcnt;
   logic [GW-1:0]    win;
   logic             found;
   int               idx;
   logic [7:0]       cmd;
   logic [AW-1:0]    arg;
   logic [WIDTH-1:0] msg;
   logic             grant;
   logic             expire;

   // search begins one past the previous winner
   always_comb begin
      found = 1'b0;
      win   = last_grant;
      idx   = 0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(last_grant) + k) % NREQ;
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            win   = GW'(idx);
         end
      end
   end

   always_comb begin
      cmd = req_cmd[8*int'(win) +: 8];
      arg = req_arg[AW*int'(win) +: AW];
      msg = {arg, cmd};
      case (cmd)
         8'h01: msg[WIDTH-1] = 1'b1;
         8'h02: if (msg[23:8] == 16'h0000) msg[8] = 1'b1;
         default: ;
      endcase
   end

   assign grant  = (state == IDLE) && found && !wr_busy;
   assign expire = (state == WAIT_START) && !wr_busy && (tcnt == TO_LAST);

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:       if (grant) state_nxt = LOAD;
         LOAD:       state_nxt = WAIT_START;
         WAIT_START: begin
            if (wr_busy)     state_nxt = WAIT_DONE;
            else if (expire) state_nxt = IDLE;
         end
         WAIT_DONE:  if (!wr_busy) state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         wr_data     <= '0;
         last_grant  <= PTR_RST;
         err_timeout <= 1'b0;
         msg_count   <= 16'h0000;
         tcnt        <= 16'h0000;
      end else begin
         state <= state_nxt;
         if (grant) begin
            wr_data    <= msg;
            last_grant <= win;
         end
         if (state == LOAD) msg_count <= msg_count + 16'h0001;
         if (state == WAIT_START) tcnt <= tcnt + 16'h0001;
         else                     tcnt <= 16'h0000;
         if (expire)         err_timeout <= 1'b1;
         else if (err_clear) err_timeout <= 1'b0;
      end
   end

   assign wr_load = (state == LOAD);
   assign busy    = (state != IDLE);
   assign req_ack = (state == LOAD) ? (NREQ'(1) << last_grant) : '0;

endmodule

// File: tb/tb_ipc_cmd_scheduler.sv
// Directed bench for ipc_cmd_scheduler with a simple writer model
// that goes busy for blen cycles starting the cycle after a load.
module tb_ipc_cmd_scheduler;

   localparam int NREQ = 4;
   localparam int WIDTH = 64;
   localparam int AW = WIDTH - 8;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [NREQ-1:0]      req_valid = '0;
   logic [NREQ*8-1:0]    req_cmd = '0;
   logic [NREQ*AW-1:0]   req_arg = '0;
   logic [NREQ-1:0]      req_ack;
   logic [WIDTH-1:0]     wr_data;
   logic                 wr_load;
   logic                 wr_busy = 1'b0;
   logic                 busy;
   logic [1:0]           last_grant;
   logic                 err_timeout;
   logic                 err_clear = 1'b0;
   logic [15:0]          msg_count;

   int total = 0;
   int bad = 0;
   int blen = 1;
   int rem = 0;

   ipc_cmd_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_cmd(req_cmd), .req_arg(req_arg),
      .req_ack(req_ack), .wr_data(wr_data), .wr_load(wr_load),
      .wr_busy(wr_busy), .busy(busy), .last_grant(last_grant),
      .err_timeout(err_timeout), .err_clear(err_clear),
      .msg_count(msg_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rem > 0) begin
         wr_busy = 1'b1;
         rem = rem - 1;
      end else begin
         wr_busy = 1'b0;
      end
      if (wr_load) rem = blen;
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [7:0] c,
                          input logic [AW-1:0] a);
      req_cmd[8*i +: 8] = c;
      req_arg[AW*i +: AW] = a;
      req_valid[i] = 1'b1;
   endtask

   task automatic wait_load();
      bit seen = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (wr_load) begin
            seen = 1;
            break;
         end
      end
      if (!seen) chk("load_timeout", 0, 1);
   endtask

   task automatic wait_idle();
      bit seen = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (!busy) begin
            seen = 1;
            break;
         end
      end
      if (!seen) chk("idle_timeout", 0, 1);
   endtask

   task automatic one(input string tag, input int r, input logic [7:0] c,
                      input logic [AW-1:0] a, input logic [63:0] exp);
      @(negedge clk);
      set_req(r, c, a);
      wait_load();
      chk({tag, "_data"}, wr_data, exp);
      chk({tag, "_ack"}, 64'(req_ack), 64'(4'b0001 << r));
      req_valid = '0;
      wait_idle();
   endtask

   initial begin
      #12;
      chk("rst_busy", 64'(busy), 0);
      chk("rst_load", 64'(wr_load), 0);
      chk("rst_ack", 64'(req_ack), 0);
      chk("rst_data", wr_data, 0);
      chk("rst_grant", 64'(last_grant), 3);
      chk("rst_err", 64'(err_timeout), 0);
      chk("rst_cnt", 64'(msg_count), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // single request, decimator factor 0 replaced by 1
      blen = 1;
      @(negedge clk);
      set_req(2, 8'h02, '0);
      @(negedge clk);
      chk("s_load", 64'(wr_load), 1);
      chk("s_ack", 64'(req_ack), 64'h4);
      chk("s_cmd", 64'(wr_data[7:0]), 64'h02);
      chk("s_fac", 64'(wr_data[23:8]), 64'h0001);
      chk("s_busy", 64'(busy), 1);
      chk("s_grant", 64'(last_grant), 2);
      req_valid = '0;
      @(negedge clk);
      chk("s_cnt", 64'(msg_count), 1);
      chk("s_load2", 64'(wr_load), 0);
      chk("s_ack2", 64'(req_ack), 0);
      wait_idle();

      one("mc", 1, 8'h01, '0, 64'h8000_0000_0000_0001);
      one("dec", 3, 8'h02, 56'h11_2233_4455_1234, 64'h1122_3344_5512_3402);
      one("dec0", 0, 8'h02, 56'hFF_0000_0000_0000, 64'hFF00_0000_0000_0102);
      one("pass", 2, 8'h7F, 56'h80_0000_0000_0000, 64'h8000_0000_0000_007F);
      chk("cnt5", 64'(msg_count), 5);

      // round-robin from a fresh pointer
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      blen = 3;
      for (int i = 0; i < NREQ; i++) set_req(i, 8'(8'h10 + i), AW'(i));
      for (int g = 0; g < 5; g++) begin
         wait_load();
         chk("rr_ack", 64'(req_ack), 64'(4'b0001 << (g % 4)));
         chk("rr_grant", 64'(last_grant), 64'(g % 4));
         chk("rr_cmd", 64'(wr_data[7:0]), 64'(8'h10 + (g % 4)));
      end
      req_valid = '0;
      wait_idle();
      chk("rr_cnt", 64'(msg_count), 5);

      // writer never starts
      blen = 0;
      @(negedge clk);
      set_req(0, 8'h05, '0);
      wait_load();
      req_valid = '0;
      repeat (8) @(negedge clk);
      chk("to_busy", 64'(busy), 1);
      chk("to_err0", 64'(err_timeout), 0);
      @(negedge clk);
      chk("to_idle", 64'(busy), 0);
      chk("to_err1", 64'(err_timeout), 1);

      set_req(1, 8'h06, '0);
      wait_load();
      req_valid = '0;
      repeat (8) @(negedge clk);
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      chk("to2_err", 64'(err_timeout), 1);
      chk("to2_idle", 64'(busy), 0);
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      chk("clr_err", 64'(err_timeout), 0);
      chk("to_cnt", 64'(msg_count), 7);

      // reset while the writer is transmitting
      blen = 5;
      @(negedge clk);
      set_req(2, 8'h09, '0);
      wait_load();
      req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      chk("md_busy", 64'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mr_busy", 64'(busy), 0);
      chk("mr_load", 64'(wr_load), 0);
      chk("mr_ack", 64'(req_ack), 0);
      chk("mr_grant", 64'(last_grant), 3);
      blen = 0;
      repeat (8) @(negedge clk);
      req_valid = 4'b1111;
      rst_n = 1'b1;
      wait_load();
      chk("mr_first", 64'(req_ack), 64'h1);
      req_valid = '0;
      wait_idle();
      chk("mr_cnt", 64'(msg_count), 1);

      // counter wrap
      blen = 1;
      @(negedge clk);
      force dut.msg_count = 16'hFFFF;
      @(posedge clk);
      #1 release dut.msg_count;
      @(negedge clk);
      chk("wr_pre", 64'(msg_count), 64'hFFFF);
      set_req(3, 8'h20, '0);
      wait_load();
      req_valid = '0;
      @(negedge clk);
      chk("wr_wrap", 64'(msg_count), 0);
      wait_idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ipc_cmd_scheduler.md
# ipc_cmd_scheduler

Arbitrates between several IPC command requesters and sequences the single message writer. Each granted request is formatted into one `WIDTH`-bit IPC message and loaded into the writer. The block then waits for the writer to accept and finish the message before the next grant. It sits between the control-side requesters and the writer, and replaces ad-hoc direct driving of the writer's load input.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `WIDTH`, default 64: message width; the command occupies `[7:0]` and the argument occupies `[WIDTH-1:8]`.
- `TIMEOUT`, default 255: maximum cycles to wait for the writer to assert busy after a load; 1..65535.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req_valid`, input, `NREQ`: request pending, one bit per requester.
- `req_cmd`, input, `NREQ*8`: command code; requester i uses bits `[8i+7:8i]`.
- `req_arg`, input, `NREQ*(WIDTH-8)`: argument field, packed per requester.
- `req_ack`, output, `NREQ`: one-cycle one-hot pulse meaning the request was captured.
- `wr_data`, output, `WIDTH`: formatted message; held stable from LOAD until the next grant.
- `wr_load`, output, 1: one-cycle load strobe to the writer.
- `wr_busy`, input, 1: writer is transmitting.
- `busy`, output, 1: high whenever the state is not IDLE.
- `last_grant`, output, `$clog2(NREQ)`: index of the most recent grant.
- `err_timeout`, output, 1: sticky flag; the writer never asserted busy after a load.
- `err_clear`, input, 1: clears `err_timeout`.
- `msg_count`, output, 16: number of messages loaded; wraps from 65535 to 0.

## Operation
- States: IDLE, LOAD, WAIT_START, WAIT_DONE.
- **IDLE:** if any `req_valid` is set and `wr_busy`=0, select a winner by round-robin, then at that clock edge:
  - capture `req_cmd`/`req_arg` into `wr_data`;
  - record the winner in `last_grant`;
  - go to LOAD.
- If `wr_busy`=1 in IDLE, no grant is made.
- **Round-robin:** search starts at `last_grant+1`, modulo `NREQ`. After reset the pointer is `NREQ-1`, so requester 0 has first priority.
- **LOAD:** lasts exactly one cycle.
  - `wr_load`=1 and `req_ack[last_grant]`=1, both decoded from the registered state.
  - `msg_count` increments by 1.
  - Next state is WAIT_START.
- **WAIT_START:** go to WAIT_DONE when `wr_busy`=1. If `TIMEOUT` cycles elapse with `wr_busy`=0, set `err_timeout` and go to IDLE; the message is dropped and not retried.
- **WAIT_DONE:** go to IDLE when `wr_busy`=0.
- **Message formatting:**
  - Base message: `wr_data[7:0]` = cmd, `wr_data[WIDTH-1:8]` = arg.
  - SET_MASTER_CONFIG (8'h01): `wr_data[WIDTH-1]` is forced to 1.
  - SET_PROG_DECIMATOR (8'h02): `arg[15:0]` is the decimation factor. A value of 0 is illegal and is replaced by 1; all other bits pass through.
  - Any other code passes through unmodified.
- **Requester contract:**
  - Hold `req_valid`/`req_cmd`/`req_arg` stable until `req_ack`.
  - Deassert `req_valid`, or present the next request, in the cycle after `req_ack`.
  - A requester dropping `req_valid` before it is granted is legal; that request is simply not serviced.
- **`err_timeout`:** set has priority over `err_clear` in the same cycle.
- **Reset (asynchronous):**
  - state = IDLE;
  - `wr_data` = 0, `wr_load` = 0, `req_ack` = 0, `busy` = 0;
  - `last_grant` = `NREQ-1`, `err_timeout` = 0, `msg_count` = 0, timeout counter = 0.
- **Reset mid-operation:** aborts immediately with no `wr_load` or `req_ack` pulse. The writer is not otherwise signalled.

## Timing
- `req_valid` sampled high in IDLE at edge N: `req_ack`, `wr_load` and the new `wr_data` are all valid in cycle N+1. `busy` rises in cycle N+1.
- The earliest re-grant comes 1 cycle after `wr_busy` falls: the WAIT_DONE→IDLE edge, then the IDLE grant edge, then LOAD.
- Minimum message period is 4 cycles: writer busy for 1 cycle, starting the cycle after LOAD.
- Timeout: the counter starts at 0 on entry to WAIT_START. `err_timeout` is set at the edge where the counter reaches `TIMEOUT-1` with `wr_busy` still 0, i.e. exactly `TIMEOUT` cycles spent in WAIT_START.
- `wr_busy` already high in the LOAD cycle: it is still sampled in WAIT_START and exits on the first WAIT_START cycle.
- All outputs are registered or decoded from registered state. There are no combinational input→output paths.

## Test plan
- **Single request:** reset, then req 2 with cmd=8'h02, `arg[15:0]`=0 → `wr_load` and `req_ack`=4'b0100 one cycle after sampling; `wr_data[7:0]`=8'h02, `wr_data[23:8]`=16'h0001; `msg_count`=1.
- **Master config:** cmd=8'h01, arg=0 → `wr_data`=64'h8000_0000_0000_0001.
- **Round-robin:** all four `req_valid` held high, writer busy 3 cycles per message → grant order 0,1,2,3,0; no requester acked twice in a row.
- **Timeout:** `TIMEOUT`=8, `wr_busy` tied 0 → `err_timeout` rises after 8 WAIT_START cycles and the block returns to IDLE. Then `err_clear` asserted in the same cycle as a second timeout → flag stays 1.
- **Reset mid-WAIT_DONE:** assert `rst_n`=0 → `busy`, `wr_load` and `req_ack` go 0 immediately; after release the first grant goes to req 0.
- **Counter wrap:** preload via 65536 loads (or force) → `msg_count` wraps from 65535 to 0.
